// File: rtl/ip_pkg.sv
// ============================================================================
//  Module : ip_pkg
//  Brief  : Shared types for the instruction-pointer unit and checkpoint stack.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ip_pkg;

    localparam int IP_ADDR_W = 16;

    typedef enum logic [2:0] {
        IP_SRC_WR   = 3'd0,
        IP_SRC_POP  = 3'd1,
        IP_SRC_RB   = 3'd2,
        IP_SRC_BR   = 3'd3,
        IP_SRC_INC  = 3'd4,
        IP_SRC_HOLD = 3'd5
    } ip_src_e;

    typedef struct packed {
        logic [IP_ADDR_W-1:0] val;
        logic [IP_ADDR_W-1:0] start_val;
    } ckpt_entry_t;

endpackage

`default_nettype wire

// File: rtl/ip_ckpt_stack.sv
// ============================================================================
//  Module : ip_ckpt_stack
//  Brief  : LIFO of IP checkpoints with push, pop, swap, full/empty, error strobe.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ip_ckpt_stack
    import ip_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = $bits(ckpt_entry_t)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic              err
);

    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS = 1 << IDX_W;

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] mem_q [SLOTS];
    logic [DATA_W-1:0] mem_d [SLOTS];
    logic [IDX_W-1:0]  w_top_idx;
    logic [IDX_W-1:0]  w_push_idx;

    assign empty      = (ptr_q == '0);
    assign full       = (ptr_q == PTR_W'(DEPTH));
    assign w_top_idx  = IDX_W'(ptr_q - 1'b1);
    assign w_push_idx = IDX_W'(ptr_q);
    assign rd_data    = mem_q[w_top_idx];

    // A simultaneous push+pop is a swap: the caller consumes the top and the
    // same slot takes the outgoing context, so occupancy is unchanged.
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        err   = 1'b0;
        if (push && pop) begin
            if (empty) err = 1'b1;
            else       mem_d[w_top_idx] = wr_data;
        end else if (push) begin
            if (full) begin
                err = 1'b1;
            end else begin
                mem_d[w_push_idx] = wr_data;
                ptr_d             = ptr_q + 1'b1;
            end
        end else if (pop) begin
            if (empty) err = 1'b1;
            else       ptr_d = ptr_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= '0;
            for (int i = 0; i < SLOTS; i++) mem_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            mem_q <= mem_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ip_ckpt_unit.sv
// ============================================================================
//  Module : ip_ckpt_unit
//  Brief  : Instruction-pointer unit with rollback and checkpoint stack.
//           Optional instruction-start history ring enabled by IP_HISTORY_EN.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ip_ckpt_unit
    import ip_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int INC_W      = 4,
    parameter int DISP_W     = 16,
    parameter int CKPT_DEPTH = 4,
    parameter int HIST_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_instruction,
    input  logic                          next_instruction,
    input  logic                          rollback,
    input  logic [INC_W-1:0]              inc,
    input  logic                          branch_en,
    input  logic [DISP_W-1:0]             disp,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_val,
    input  logic                          ckpt_push,
    input  logic                          ckpt_pop,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
    output logic [ADDR_W-1:0]             val,
    output logic [ADDR_W-1:0]             start_val,
    output logic                          ckpt_full,
    output logic                          ckpt_empty,
    output logic                          ckpt_err,
    output logic                          wrapped,
    output logic [ADDR_W-1:0]             hist_val
);

    localparam int HIST_IW = $clog2(HIST_DEPTH);

    logic [ADDR_W-1:0]   val_q, val_d;
    logic [ADDR_W-1:0]   start_val_q, start_val_d;
    logic                ckpt_err_q, ckpt_err_d;
    logic                wrapped_q, wrapped_d;
    ip_src_e             w_src;
    logic                w_pop_ok;
    logic                w_stk_err;
    logic [2*ADDR_W-1:0] w_stk_rd;
    logic [ADDR_W-1:0]   w_top_val, w_top_sv;
    logic [ADDR_W-1:0]   w_disp_ext;
    logic [ADDR_W:0]     w_inc_sum;
    logic [ADDR_W+1:0]   w_br_sum;
    logic                w_br_out;

    if (DISP_W >= ADDR_W) begin : g_disp_trunc
        assign w_disp_ext = disp[ADDR_W-1:0];
    end else begin : g_disp_sext
        assign w_disp_ext = {{(ADDR_W-DISP_W){disp[DISP_W-1]}}, disp};
    end

    // Two guard bits: 01 = carried past the top, 11 = borrowed below zero.
    assign w_inc_sum = {1'b0, val_q} + (ADDR_W+1)'(inc);
    assign w_br_sum  = {2'b00, val_q} + {{2{w_disp_ext[ADDR_W-1]}}, w_disp_ext};
    assign w_br_out  = (w_br_sum[ADDR_W+1:ADDR_W] != 2'b00);

    ip_ckpt_stack #(
        .DEPTH  (CKPT_DEPTH),
        .DATA_W (2*ADDR_W)
    ) u_stack (
        .clk     (clk),
        .reset   (reset),
        .push    (ckpt_push),
        .pop     (ckpt_pop),
        .wr_data ({val_q, start_val_q}),
        .rd_data (w_stk_rd),
        .full    (ckpt_full),
        .empty   (ckpt_empty),
        .err     (w_stk_err)
    );

    assign {w_top_val, w_top_sv} = w_stk_rd;
    assign w_pop_ok = ckpt_pop && !ckpt_empty;

    always_comb begin
        w_src = IP_SRC_HOLD;
        if (wr_en)                  w_src = IP_SRC_WR;
        else if (w_pop_ok)          w_src = IP_SRC_POP;
        else if (rollback)          w_src = IP_SRC_RB;
        else if (branch_en)         w_src = IP_SRC_BR;
        else if (start_instruction) w_src = IP_SRC_INC;
    end

    always_comb begin
        val_d     = val_q;
        wrapped_d = 1'b0;
        case (w_src)
            IP_SRC_WR:  val_d = wr_val;
            IP_SRC_POP: val_d = w_top_val;
            IP_SRC_RB:  val_d = start_val_q;
            IP_SRC_BR: begin
                val_d     = w_br_sum[ADDR_W-1:0];
                wrapped_d = w_br_out;
            end
            IP_SRC_INC: begin
                val_d     = w_inc_sum[ADDR_W-1:0];
                wrapped_d = w_inc_sum[ADDR_W];
            end
            default:    val_d = val_q;
        endcase

        // A restored checkpoint carries its own start address and wins.
        start_val_d = start_val_q;
        if (w_pop_ok)                start_val_d = w_top_sv;
        else if (next_instruction)   start_val_d = val_d;
        else if (w_src == IP_SRC_INC) start_val_d = val_q;

        ckpt_err_d = ckpt_err_q | w_stk_err;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            val_q       <= '0;
            start_val_q <= '0;
            ckpt_err_q  <= 1'b0;
            wrapped_q   <= 1'b0;
        end else begin
            val_q       <= val_d;
            start_val_q <= start_val_d;
            ckpt_err_q  <= ckpt_err_d;
            wrapped_q   <= wrapped_d;
        end
    end

    assign val       = val_q;
    assign start_val = start_val_q;
    assign ckpt_err  = ckpt_err_q;
    assign wrapped   = wrapped_q;

`ifdef IP_HISTORY_EN
    logic [ADDR_W-1:0]  hist_q [HIST_DEPTH];
    logic [ADDR_W-1:0]  hist_d [HIST_DEPTH];
    logic [HIST_IW-1:0] hist_wp_q, hist_wp_d;

    always_comb begin
        hist_d    = hist_q;
        hist_wp_d = hist_wp_q;
        if (w_src == IP_SRC_INC) begin
            hist_d[hist_wp_q] = val_q;
            hist_wp_d         = hist_wp_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hist_wp_q <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
        end else begin
            hist_wp_q <= hist_wp_d;
            hist_q    <= hist_d;
        end
    end

    // The write pointer sits one past the newest entry; ring depth is 2**n.
    assign hist_val = hist_q[HIST_IW'(hist_wp_q - 1'b1 - hist_idx)];
`else
    logic w_unused_hist;
    assign w_unused_hist = ^hist_idx;
    assign hist_val      = '0;
`endif

endmodule

`default_nettype wire
